// File: rtl/br_issue_seq.sv
// Branch issue sequencer feeding tage_predictor; optional stats via BR_ISSUE_SEQ_STATS_EN.
// Latency: record pushed at edge N is issuable in cycle N+1; one branch per cycle.
// Backpressure: trace_ready_o drops while the FIFO is full; issue stalls while run_i is low.
module br_issue_seq #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WARMUP_BR  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        trace_valid_i,
    output logic        trace_ready_o,
    input  logic [31:0] trace_pc_i,
    input  logic        trace_taken_i,
    input  logic        run_i,
    input  logic        stat_clear_i,
    output logic        pred_en_o,
    output logic [31:0] pred_idx_o,
    output logic        pred_br_result_o,
    output logic        pred_correct_o,
    input  logic        prediction_i,
    output logic [31:0] stat_branches_o,
    output logic [31:0] stat_mispred_o,
    output logic [1:0]  state_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WARMUP  = 2'd1,
        S_MEASURE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic [31:0]           r_mem_pc [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_mem_taken;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_head_taken;
    logic                  w_clear;
    logic                  w_warm_done;

`ifdef BR_ISSUE_SEQ_STATS_EN
    localparam bit WARM_EN = (WARMUP_BR != 0);
`else
    localparam bit WARM_EN = 1'b0;
`endif

    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_full        = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                           (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign trace_ready_o = !w_full;
    assign w_push        = trace_valid_i && !w_full;
    assign pred_en_o     = !w_empty && run_i && (r_state != S_IDLE);
    assign w_pop         = pred_en_o;

    assign w_head_taken     = r_mem_taken[r_rd_ptr[AW-1:0]];
    assign pred_idx_o       = w_empty ? 32'd0 : r_mem_pc[r_rd_ptr[AW-1:0]];
    assign pred_br_result_o = !w_empty && w_head_taken;
    // Non-step cycles report "correct" so the predictor never allocates on them.
    assign pred_correct_o   = pred_en_o ? (prediction_i == w_head_taken) : 1'b1;
    assign state_o          = r_state;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem_pc[r_wr_ptr[AW-1:0]]    <= trace_pc_i;
            r_mem_taken[r_wr_ptr[AW-1:0]] <= trace_taken_i;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (run_i) w_state_nxt = WARM_EN ? S_WARMUP : S_MEASURE;
            S_WARMUP:  if (!run_i) w_state_nxt = S_IDLE;
                       else if (!w_clear && w_warm_done) w_state_nxt = S_MEASURE;
            S_MEASURE: if (!run_i) w_state_nxt = S_IDLE;
                       else if (w_clear && WARM_EN) w_state_nxt = S_WARMUP;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

`ifdef BR_ISSUE_SEQ_STATS_EN
    logic [31:0] r_warm_cnt;
    logic [31:0] r_stat_br;
    logic [31:0] r_stat_mispred;
    logic        w_warm_inc;
    logic        w_meas_inc;

    assign w_clear    = stat_clear_i;
    assign w_warm_inc = w_pop && (r_state == S_WARMUP);
    assign w_meas_inc = w_pop && (r_state == S_MEASURE);
    // Includes this cycle's issue so the switch lands on the edge issuing branch WARMUP_BR.
    assign w_warm_done = ({1'b0, r_warm_cnt} + 33'(w_warm_inc)) >= 33'(WARMUP_BR);

    always_ff @(posedge clk_i) begin
        if (!rst_ni || w_clear) begin
            r_warm_cnt     <= '0;
            r_stat_br      <= '0;
            r_stat_mispred <= '0;
        end else begin
            if (w_warm_inc) r_warm_cnt <= r_warm_cnt + 32'd1;
            if (w_meas_inc && (r_stat_br != 32'hFFFF_FFFF))
                r_stat_br <= r_stat_br + 32'd1;
            if (w_meas_inc && !pred_correct_o && (r_stat_mispred != 32'hFFFF_FFFF))
                r_stat_mispred <= r_stat_mispred + 32'd1;
        end
    end

    assign stat_branches_o = r_stat_br;
    assign stat_mispred_o  = r_stat_mispred;
`else
    logic w_unused;
    assign w_clear         = 1'b0;
    assign w_warm_done     = 1'b1;
    assign stat_branches_o = 32'd0;
    assign stat_mispred_o  = 32'd0;
    assign w_unused        = ^{stat_clear_i, WARMUP_BR};
`endif

endmodule
